// File: rtl/playbus_pkg.sv
// PlayBus transfer controller shared types.
// Holds the function/state encodings and the per-function source/sink decode table
// used by the controller and its sub-blocks.
package playbus_pkg;

    typedef enum logic [2:0] {
        FN_ROM     = 3'd0,  // ROM -> bus (static)
        FN_RAM     = 3'd1,  // RAM -> bus (static)
        FN_SW      = 3'd2,  // switches -> bus (static)
        FN_SW2RAM  = 3'd3,
        FN_ROM2RAM = 3'd4,
        FN_SW2LED  = 3'd5,
        FN_RAM2LED = 3'd6,
        FN_BLK     = 3'd7   // block ROM -> RAM, ADD .. top of memory
    } fn_e;

    // Codes are visible on St, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_NEXT     = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ROM  = 2'd1,
        SRC_RAM  = 2'd2,
        SRC_SW   = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        SNK_NONE = 2'd0,
        SNK_RAM  = 2'd1,
        SNK_LED  = 2'd2
    } snk_e;

    // Dwell timer width; comfortably covers any practical *_CYC setting.
    localparam int TMR_W = 8;

    function automatic logic is_dynamic(input fn_e fn);
        return (fn >= FN_SW2RAM);
    endfunction

    // Bus source driven for a function (static functions included).
    function automatic src_e fn_src(input fn_e fn);
        src_e s;
        case (fn)
            FN_ROM, FN_ROM2RAM, FN_BLK: s = SRC_ROM;
            FN_RAM, FN_RAM2LED:         s = SRC_RAM;
            FN_SW, FN_SW2RAM, FN_SW2LED: s = SRC_SW;
            default:                    s = SRC_NONE;
        endcase
        return s;
    endfunction

    // Sink strobed for a dynamic function.
    function automatic snk_e fn_snk(input fn_e fn);
        snk_e k;
        case (fn)
            FN_SW2RAM, FN_ROM2RAM, FN_BLK: k = SNK_RAM;
            FN_SW2LED, FN_RAM2LED:         k = SNK_LED;
            default:                       k = SNK_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/playbus_xfer_ctrl_timer.sv
// pb_dwell_timer: loadable down-counter timing how long the controller dwells in a state.
// Ports: i_clk/i_rst clock and async active-high reset; i_load/i_val reload the count;
// o_expired is high once the count has reached zero (immediately if loaded with zero).
module pb_dwell_timer
    import playbus_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_val,
    output logic             o_expired
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/playbus_xfer_ctrl.sv
// PlayBus transfer controller: decodes FUNC, drives the active-low bus source enables,
// generates registered sink strobes and sequences single-word and block transfers.
// Ports: CK2HZ/CLR clock and async reset; GO/FUNC/ADD front panel; ADDR_OUT address bus;
// n_ROMO/n_RAMO/n_SWBEN source enables; n_RAMW/LEDLTCH sink strobes; BUSY; St state code.
module playbus_xfer_ctrl
    import playbus_pkg::*;
#(
    parameter int AW        = 4,
    parameter int SETUP_CYC = 1,
    parameter int WR_CYC    = 1,
    parameter int HOLD_CYC  = 1
)(
    input  logic          CK2HZ,
    input  logic          CLR,
    input  logic          GO,
    input  logic [2:0]    FUNC,
    input  logic [AW-1:0] ADD,
    output logic [AW-1:0] ADDR_OUT,
    output logic          n_ROMO,
    output logic          n_RAMO,
    output logic          n_SWBEN,
    output logic          n_RAMW,
    output logic          LEDLTCH,
    output logic          BUSY,
    output logic [2:0]    St
);

    state_e           r_state;
    state_e           w_state_nxt;
    fn_e              r_fn;
    logic [AW-1:0]    r_addr;
    logic             r_ramw_n;
    logic             r_ledltch;

    logic             w_start;
    logic             w_addr_inc;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_exp;
    fn_e              w_func;
    src_e             w_src;

    assign w_func = fn_e'(FUNC);

    pb_dwell_timer u_timer (
        .i_clk     (CK2HZ),
        .i_rst     (CLR),
        .i_load    (w_tmr_load),
        .i_val     (w_tmr_val),
        .o_expired (w_tmr_exp)
    );

    // State register.
    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, timer reload and bus source selection.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_addr_inc  = 1'b0;
        w_src       = SRC_NONE;

        case (r_state)
            ST_IDLE: begin
                // Static functions drive the bus straight from the switches.
                if (!is_dynamic(w_func)) begin
                    w_src = fn_src(w_func);
                end else if (GO) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_src = fn_src(r_fn);
                if (w_tmr_exp) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_src = fn_src(r_fn);
                if (w_tmr_exp) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_src = fn_src(r_fn);
                if (w_tmr_exp) begin
                    // The block counter stops at the top word instead of wrapping.
                    if (r_fn == FN_BLK && r_addr != {AW{1'b1}}) w_state_nxt = ST_NEXT;
                    else                                      w_state_nxt = ST_WAIT_REL;
                end
            end
            ST_NEXT: begin
                w_addr_inc  = 1'b1;
                w_state_nxt = ST_SETUP;
            end
            ST_WAIT_REL: begin
                if (!GO) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Every state entry restarts the dwell timer; a load of N gives N+1 cycles.
        w_tmr_load = (w_state_nxt != r_state);
        case (w_state_nxt)
            ST_SETUP: w_tmr_val = TMR_W'(SETUP_CYC - 1);
            ST_WRITE: w_tmr_val = TMR_W'(WR_CYC - 1);
            ST_HOLD:  w_tmr_val = TMR_W'(HOLD_CYC - 1);
            default:  w_tmr_val = '0;
        endcase
    end

    // Transfer context, frozen from start until the controller is idle again.
    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            r_fn   <= FN_ROM;
            r_addr <= '0;
        end else if (w_start) begin
            r_fn   <= w_func;
            r_addr <= ADD;
        end else if (w_addr_inc) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Strobes are decoded from the next state so the flop output is high exactly for
    // the WRITE cycles; only SETUP precedes WRITE, so r_fn is already valid here.
    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            r_ramw_n  <= 1'b1;
            r_ledltch <= 1'b0;
        end else begin
            r_ramw_n  <= !(w_state_nxt == ST_WRITE && fn_snk(r_fn) == SNK_RAM);
            r_ledltch <=  (w_state_nxt == ST_WRITE && fn_snk(r_fn) == SNK_LED);
        end
    end

    assign n_ROMO   = (w_src != SRC_ROM);
    assign n_RAMO   = (w_src != SRC_RAM);
    assign n_SWBEN  = (w_src != SRC_SW);
    assign n_RAMW   = r_ramw_n;
    assign LEDLTCH  = r_ledltch;
    assign BUSY     = (r_state != ST_IDLE);
    assign St       = r_state;
    assign ADDR_OUT = BUSY ? r_addr : ADD;

endmodule

// File: tb/tb_playbus_xfer_ctrl.sv
// Self-checking bench for playbus_xfer_ctrl: one default build and one with longer
// setup/write dwell. Expected per-cycle output vectors are queued when stimulus is
// applied and compared at each following falling edge.
module tb_playbus_xfer_ctrl;

    logic       clk;
    logic       clr;
    logic       go,  go2;
    logic [2:0] func, func2;
    logic [3:0] add, add2;

    logic [3:0] addr_out, addr_out2;
    logic       n_romo, n_ramo, n_swben, n_ramw, ledltch, busy;
    logic       n_romo2, n_ramo2, n_swben2, n_ramw2, ledltch2, busy2;
    logic [2:0] st, st2;

    playbus_xfer_ctrl #(.AW(4)) dut (
        .CK2HZ(clk), .CLR(clr), .GO(go), .FUNC(func), .ADD(add),
        .ADDR_OUT(addr_out), .n_ROMO(n_romo), .n_RAMO(n_ramo), .n_SWBEN(n_swben),
        .n_RAMW(n_ramw), .LEDLTCH(ledltch), .BUSY(busy), .St(st)
    );

    playbus_xfer_ctrl #(.AW(4), .SETUP_CYC(2), .WR_CYC(3), .HOLD_CYC(1)) dut2 (
        .CK2HZ(clk), .CLR(clr), .GO(go2), .FUNC(func2), .ADD(add2),
        .ADDR_OUT(addr_out2), .n_ROMO(n_romo2), .n_RAMO(n_ramo2), .n_SWBEN(n_swben2),
        .n_RAMW(n_ramw2), .LEDLTCH(ledltch2), .BUSY(busy2), .St(st2)
    );

    // {St, n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, BUSY, ADDR_OUT}
    logic [12:0] obs1, obs2;
    assign obs1 = {st,  n_romo,  n_ramo,  n_swben,  n_ramw,  ledltch,  busy,  addr_out};
    assign obs2 = {st2, n_romo2, n_ramo2, n_swben2, n_ramw2, ledltch2, busy2, addr_out2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected outputs for a state. src: 0 none, 1 ROM, 2 RAM, 3 SW; snk: 0 none, 1 RAM, 2 LED.
    // In IDLE the caller passes the static source (or none for a dynamic FUNC).
    function automatic logic [12:0] ev(input logic [2:0] s, input int src, input int snk,
                                       input logic [3:0] a);
        logic en, wr;
        en = (s <= 3'd3);
        wr = (s == 3'd2);
        return {s, !(en && src == 1), !(en && src == 2), !(en && src == 3),
                !(wr && snk == 1), (wr && snk == 2), (s != 3'd0), a};
    endfunction

    task automatic push(input logic [2:0] s, input int src, input int snk, input logic [3:0] a);
        exp_q.push_back(ev(s, src, snk, a));
    endtask

    task automatic drain(input string tag, input bit use2, input bit wait_edge);
        logic [12:0] e, o;
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            if (wait_edge) @(negedge clk);
            else           #1;
            e = exp_q.pop_front();
            o = use2 ? obs2 : obs1;
            chk($sformatf("%s.%0d", tag, i), 32'(o), 32'(e));
            chk($sformatf("%s.%0d.onehot", tag, i), 32'($countones(~o[9:7]) <= 1), 32'd1);
            i++;
        end
    endtask

    initial begin
        clr = 1'b1; go = 1'b0; func = 3'd4; add = 4'd3;
        go2 = 1'b0; func2 = 3'd0; add2 = 4'd0;

        // Reset state: dynamic FUNC, so every enable is inactive.
        push(3'd0, 0, 0, 4'd3);
        push(3'd0, 0, 0, 4'd3);
        drain("reset", 0, 1);
        clr = 1'b0;

        // 1: static functions follow FUNC, GO ignored.
        for (int f = 0; f < 3; f++) begin
            for (int g = 0; g < 2; g++) begin
                func = 3'(f);
                go   = 1'(g);
                push(3'd0, f + 1, 0, 4'd3);
                push(3'd0, f + 1, 0, 4'd3);
                drain($sformatf("static_f%0d_g%0d", f, g), 0, 1);
            end
        end
        go = 1'b0;

        // 2: SW -> LED, GO held high stays in WAIT_REL.
        func = 3'd5; add = 4'd9; go = 1'b1;
        push(3'd1, 3, 2, 4'd9);
        push(3'd2, 3, 2, 4'd9);
        push(3'd3, 3, 2, 4'd9);
        push(3'd5, 3, 2, 4'd9);
        push(3'd5, 3, 2, 4'd9);
        push(3'd5, 3, 2, 4'd9);
        drain("sw2led", 0, 1);
        go = 1'b0;
        push(3'd0, 0, 0, 4'd9);
        drain("sw2led_rel", 0, 1);

        // 3: block copy 13..15.
        func = 3'd7; add = 4'd13; go = 1'b1;
        for (int w = 0; w < 3; w++) begin
            push(3'd1, 1, 1, 4'(13 + w));
            push(3'd2, 1, 1, 4'(13 + w));
            push(3'd3, 1, 1, 4'(13 + w));
            if (w < 2) push(3'd4, 1, 1, 4'(13 + w));
        end
        push(3'd5, 1, 1, 4'd15);
        drain("blk13", 0, 1);
        go = 1'b0;
        push(3'd0, 0, 0, 4'd13);
        drain("blk13_rel", 0, 1);

        // 3b: block copy from the top word copies exactly one word.
        add = 4'd15; go = 1'b1;
        push(3'd1, 1, 1, 4'd15);
        push(3'd2, 1, 1, 4'd15);
        push(3'd3, 1, 1, 4'd15);
        push(3'd5, 1, 1, 4'd15);
        drain("blk15", 0, 1);
        go = 1'b0;
        push(3'd0, 0, 0, 4'd15);
        drain("blk15_rel", 0, 1);

        // 4: FUNC/ADD changed mid-SETUP are ignored.
        func = 3'd3; add = 4'd5; go = 1'b1;
        push(3'd1, 3, 1, 4'd5);
        drain("sw2ram_setup", 0, 1);
        func = 3'd6; add = 4'd2;
        push(3'd2, 3, 1, 4'd5);
        push(3'd3, 3, 1, 4'd5);
        push(3'd5, 3, 1, 4'd5);
        drain("sw2ram", 0, 1);
        go = 1'b0;
        push(3'd0, 0, 0, 4'd2);
        drain("sw2ram_rel", 0, 1);

        // 5: reset during WRITE of a block copy aborts at once.
        func = 3'd7; add = 4'd0; go = 1'b1;
        push(3'd1, 1, 1, 4'd0);
        push(3'd2, 1, 1, 4'd0);
        drain("abort_pre", 0, 1);
        clr = 1'b1;
        push(3'd0, 0, 0, 4'd0);
        drain("abort_now", 0, 0);
        push(3'd0, 0, 0, 4'd0);
        drain("abort_held", 0, 1);
        go = 1'b0;
        clr = 1'b0;
        for (int c = 0; c < 4; c++) push(3'd0, 0, 0, 4'd0);
        drain("abort_after", 0, 1);

        // 6: longer setup/write build, RAM -> LED.
        func2 = 3'd6; add2 = 4'd7; go2 = 1'b1;
        push(3'd1, 2, 2, 4'd7);
        push(3'd1, 2, 2, 4'd7);
        push(3'd2, 2, 2, 4'd7);
        push(3'd2, 2, 2, 4'd7);
        push(3'd2, 2, 2, 4'd7);
        push(3'd3, 2, 2, 4'd7);
        push(3'd5, 2, 2, 4'd7);
        drain("long_ram2led", 1, 1);
        go2 = 1'b0;
        push(3'd0, 0, 0, 4'd7);
        drain("long_rel", 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
